// File: rtl/ledstrip_frame_seq.sv
// Pixel buffer plus frame sequencer that streams buffered GRB pixels to an LED strip driver.
// Optional per-channel brightness scaling is enabled by defining LEDSTRIP_BRIGHTNESS_EN.
`timescale 1ns/1ps
module ledstrip_frame_seq #(
  parameter int NUM_LEDS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [23:0] wr_data,
  input  logic        start,
  input  logic [4:0]  frame_len,
  input  logic [7:0]  brightness,
  output logic        busy,
  output logic        done,
  output logic [23:0] data_out,
  output logic        valid,
  output logic        latch,
  input  logic        ready
);

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  state_t      state, state_next;
  logic [3:0]  index;
  logic [4:0]  len;
  logic [4:0]  clamped_len;
  logic [23:0] pixel_mem [NUM_LEDS];
  logic [23:0] fetch_pixel;
  logic [23:0] scaled_pixel;
  logic        last_pixel;
  logic        transfer;

  assign clamped_len = (frame_len > 5'(NUM_LEDS)) ? 5'(NUM_LEDS) : frame_len;
  assign last_pixel  = ({1'b0, index} == (len - 5'd1));
  assign fetch_pixel = pixel_mem[index];
  assign transfer    = valid & ready;

`ifdef LEDSTRIP_BRIGHTNESS_EN
  // Scale by (brightness+1)/256 so brightness=255 is an exact pass-through.
  function automatic logic [7:0] scale_channel(input logic [7:0] c, input logic [7:0] b);
    return 8'((16'(c) * (16'(b) + 16'd1)) >> 8);
  endfunction

  assign scaled_pixel = {scale_channel(fetch_pixel[23:16], brightness),
                         scale_channel(fetch_pixel[15:8],  brightness),
                         scale_channel(fetch_pixel[7:0],   brightness)};
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign scaled_pixel      = fetch_pixel;
`endif

  // The buffer is only writable while idle and is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && wr_en && ({1'b0, wr_addr} < 5'(NUM_LEDS)))
      pixel_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    valid      = 1'b0;
    latch      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = (clamped_len == 5'd0) ? DONE : FETCH;
      end
      FETCH: begin
        busy       = 1'b1;
        state_next = PRESENT;
      end
      PRESENT: begin
        busy  = 1'b1;
        valid = 1'b1;
        latch = last_pixel;
        if (ready) state_next = last_pixel ? DONE : FETCH;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Frame length is captured once at acceptance so later frame_len changes are harmless.
  always_ff @(posedge clk) begin
    if (reset) begin
      index    <= 4'd0;
      len      <= 5'd0;
      data_out <= 24'd0;
    end else begin
      if (state == IDLE && start) begin
        len   <= clamped_len;
        index <= 4'd0;
      end
      if (state == FETCH)
        data_out <= scaled_pixel;
      if (transfer && !last_pixel)
        index <= index + 4'd1;
    end
  end

endmodule
